// File: rtl/ln_cordic_control_fsm_pkg.sv
// Shared definitions for the ln CORDIC control FSM.
// Holds the state encoding, the variable index constants used by the
// MS_2 / MS_3 selects, the MS_4 adder-operand select constants, a helper
// that maps a variable to its rotation partner, and the registered output
// bundle type.
package ln_cordic_control_fsm_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT_X,
        ST_WAIT_X0,
        ST_INIT_Y,
        ST_WAIT_Y0,
        ST_INIT_Z,
        ST_ROM,
        ST_SHIFT,
        ST_SEL,
        ST_ADD,
        ST_WAIT,
        ST_NEXT,
        ST_FLUSH,
        ST_FINAL,
        ST_WAIT_F,
        ST_DONE
    } state_t;

    // Variable index v, also the MS_2 / MS_3 select code.
    localparam logic [1:0] VAR_X = 2'd2;
    localparam logic [1:0] VAR_Y = 2'd1;
    localparam logic [1:0] VAR_Z = 2'd0;

    // MS_4 adder operand pairs.
    localparam logic [1:0] MS4_Z_LN16    = 2'd0;
    localparam logic [1:0] MS4_XYZ_SHIFT = 2'd1;
    localparam logic [1:0] MS4_T16_ONE   = 2'd2;

    // Hyperbolic rotation cross-couples X and Y; Z accumulates its own arctan term.
    function automatic logic [1:0] partner_of(input logic [1:0] v);
        case (v)
            VAR_X:   return VAR_Y;
            VAR_Y:   return VAR_X;
            default: return VAR_Z;
        endcase
    endfunction

    typedef struct packed {
        logic       ms_1;
        logic       en_reg3;
        logic       en_reg4;
        logic [1:0] ms_4;
        logic       add_subt;
        logic       begin_sum;
        logic       en_reg1x;
        logic       en_reg1y;
        logic       en_reg1z;
        logic [1:0] ms_2;
        logic [1:0] ms_3;
        logic       en_reg2;
        logic       clk_cdir;
        logic       en_reg2xyz;
        logic       ready;
    } ctrl_t;

endpackage

// File: rtl/ln_cordic_control_fsm.sv
// Control FSM sequencing an ln(x) CORDIC datapath.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   BEG_FSM         start request (level)
//   ACK_SUM         add/subtract unit done
//   CONT_ITERA      datapath iteration counter
//   MS_1..MS_4      datapath mux selects
//   EN_REG*         register load pulses
//   ADD_SUBT        0 = add, 1 = subtract
//   Begin_SUM       adder start pulse
//   CLK_CDIR        iteration counter increment pulse
//   READY           result register valid
// All outputs come straight from flops: the comb block decodes the state
// being entered (plus load pulses caused by the transition itself), so the
// registered value lines up with the state the FSM is in.
module ln_cordic_control_fsm
    import ln_cordic_control_fsm_pkg::*;
#(
    parameter int ITER = 24,
    parameter int D    = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         BEG_FSM,
    input  logic         ACK_SUM,
    input  logic [D-1:0] CONT_ITERA,
    output logic         MS_1,
    output logic         EN_REG3,
    output logic         EN_REG4,
    output logic [1:0]   MS_4,
    output logic         ADD_SUBT,
    output logic         Begin_SUM,
    output logic         EN_REG1X,
    output logic         EN_REG1Y,
    output logic         EN_REG1Z,
    output logic [1:0]   MS_2,
    output logic [1:0]   MS_3,
    output logic         EN_REG2,
    output logic         CLK_CDIR,
    output logic         EN_REG2XYZ,
    output logic         READY
);

    localparam logic [D-1:0] ITER_LAST = D'(ITER - 1);

    state_t     state_q, state_d;
    logic [1:0] v_q, v_d;
    logic       flush_ph_q, flush_ph_d;  // 1 = counter is incrementing this cycle
    logic       armed_q, armed_d;        // BEG_FSM has been seen low since reset
    ctrl_t      ctrl_q, ctrl_d;

    logic ld_x, ld_y, ld_z, ld_res, flush_pulse;

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        flush_ph_d  = 1'b0;
        armed_d     = armed_q | ~BEG_FSM;
        ld_x        = 1'b0;
        ld_y        = 1'b0;
        ld_z        = 1'b0;
        ld_res      = 1'b0;
        flush_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (BEG_FSM && armed_q) begin
                    state_d = ST_LOAD;
                    armed_d = 1'b0;
                end
            end
            ST_LOAD:    state_d = ST_INIT_X;
            ST_INIT_X:  state_d = ST_WAIT_X0;
            ST_WAIT_X0: begin
                if (ACK_SUM) begin
                    ld_x    = 1'b1;
                    state_d = ST_INIT_Y;
                end
            end
            ST_INIT_Y:  state_d = ST_WAIT_Y0;
            ST_WAIT_Y0: begin
                if (ACK_SUM) begin
                    ld_y    = 1'b1;
                    state_d = ST_INIT_Z;
                end
            end
            ST_INIT_Z:  state_d = ST_ROM;
            ST_ROM:     state_d = ST_SHIFT;
            ST_SHIFT:   state_d = ST_SEL;
            ST_SEL:     state_d = ST_ADD;
            ST_ADD:     state_d = ST_WAIT;
            ST_WAIT: begin
                if (ACK_SUM) begin
                    case (v_q)
                        VAR_X:   ld_x = 1'b1;
                        VAR_Y:   ld_y = 1'b1;
                        default: ld_z = 1'b1;
                    endcase
                    if (v_q == VAR_Z) begin
                        v_d     = VAR_X;
                        state_d = ST_NEXT;
                    end else begin
                        v_d     = v_q - 2'd1;
                        state_d = ST_SEL;
                    end
                end
            end
            // CONT_ITERA still holds the pre-increment value here.
            ST_NEXT: state_d = (CONT_ITERA == ITER_LAST) ? ST_FLUSH : ST_ROM;
            // Pulse on even phases only, so the count is re-examined after
            // the datapath has applied the previous increment.
            ST_FLUSH: begin
                if (!flush_ph_q) begin
                    if (CONT_ITERA == '0) begin
                        state_d = ST_FINAL;
                    end else begin
                        flush_pulse = 1'b1;
                        flush_ph_d  = 1'b1;
                    end
                end
            end
            ST_FINAL:  state_d = ST_WAIT_F;
            ST_WAIT_F: begin
                if (ACK_SUM) begin
                    ld_res  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!BEG_FSM) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ctrl_d          = '0;
        ctrl_d.en_reg1x = ld_x;
        ctrl_d.en_reg1y = ld_y;
        ctrl_d.en_reg1z = ld_z;
        ctrl_d.en_reg4  = ld_res;
        ctrl_d.clk_cdir = flush_pulse;

        case (state_d)
            ST_LOAD: ctrl_d.en_reg3 = 1'b1;
            ST_INIT_X: begin
                ctrl_d.ms_4      = MS4_T16_ONE;
                ctrl_d.begin_sum = 1'b1;
            end
            ST_WAIT_X0: ctrl_d.ms_4 = MS4_T16_ONE;
            ST_INIT_Y: begin
                ctrl_d.ms_4      = MS4_T16_ONE;
                ctrl_d.add_subt  = 1'b1;
                ctrl_d.begin_sum = 1'b1;
            end
            ST_WAIT_Y0: begin
                ctrl_d.ms_4     = MS4_T16_ONE;
                ctrl_d.add_subt = 1'b1;
            end
            ST_INIT_Z: begin
                ctrl_d.ms_1     = 1'b1;
                ctrl_d.en_reg1z = 1'b1;
            end
            ST_SHIFT: ctrl_d.en_reg2 = 1'b1;
            ST_SEL: begin
                ctrl_d.ms_2       = v_d;
                ctrl_d.en_reg2xyz = 1'b1;
            end
            ST_ADD: begin
                ctrl_d.ms_4      = MS4_XYZ_SHIFT;
                ctrl_d.ms_3      = partner_of(v_d);
                ctrl_d.begin_sum = 1'b1;
            end
            ST_WAIT: begin
                ctrl_d.ms_4 = MS4_XYZ_SHIFT;
                ctrl_d.ms_3 = partner_of(v_d);
            end
            ST_NEXT: ctrl_d.clk_cdir = 1'b1;
            ST_FINAL: begin
                ctrl_d.ms_4      = MS4_Z_LN16;
                ctrl_d.add_subt  = 1'b1;
                ctrl_d.begin_sum = 1'b1;
            end
            ST_WAIT_F: begin
                ctrl_d.ms_4     = MS4_Z_LN16;
                ctrl_d.add_subt = 1'b1;
            end
            ST_DONE: ctrl_d.ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            v_q        <= VAR_X;
            flush_ph_q <= 1'b0;
            armed_q    <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            flush_ph_q <= flush_ph_d;
            armed_q    <= armed_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign MS_1       = ctrl_q.ms_1;
    assign EN_REG3    = ctrl_q.en_reg3;
    assign EN_REG4    = ctrl_q.en_reg4;
    assign MS_4       = ctrl_q.ms_4;
    assign ADD_SUBT   = ctrl_q.add_subt;
    assign Begin_SUM  = ctrl_q.begin_sum;
    assign EN_REG1X   = ctrl_q.en_reg1x;
    assign EN_REG1Y   = ctrl_q.en_reg1y;
    assign EN_REG1Z   = ctrl_q.en_reg1z;
    assign MS_2       = ctrl_q.ms_2;
    assign MS_3       = ctrl_q.ms_3;
    assign EN_REG2    = ctrl_q.en_reg2;
    assign CLK_CDIR   = ctrl_q.clk_cdir;
    assign EN_REG2XYZ = ctrl_q.en_reg2xyz;
    assign READY      = ctrl_q.ready;

endmodule

// File: tb/tb_ln_cordic_control_fsm.sv
// Bench for ln_cordic_control_fsm. The bench plays the datapath (adder
// acknowledge, iteration counter) and checks the ordered stream of control
// pulses against a list built from the operation's sequence of steps.
module tb_ln_cordic_control_fsm;

    localparam int ITER    = 24;
    localparam int D       = 5;
    localparam int ACK_LAT = 3;

    localparam int K_REG3  = 1;
    localparam int K_R1X   = 2;
    localparam int K_R1Y   = 3;
    localparam int K_R1Z   = 4;
    localparam int K_REG2  = 5;
    localparam int K_R2XYZ = 6;
    localparam int K_BEG   = 7;
    localparam int K_CDIR  = 8;
    localparam int K_REG4  = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, beg, ack_resp, ack_force, ack_sum;
    logic [D-1:0] cont;
    logic         ms_1, en_reg3, en_reg4, add_subt, begin_sum;
    logic         en_reg1x, en_reg1y, en_reg1z, en_reg2, clk_cdir, en_reg2xyz, ready;
    logic [1:0]   ms_4, ms_2, ms_3;
    logic [17:0]  outs_vec;

    assign ack_sum  = ack_resp | ack_force;
    assign outs_vec = {ms_1, en_reg3, en_reg4, ms_4, add_subt, begin_sum, en_reg1x,
                       en_reg1y, en_reg1z, ms_2, ms_3, en_reg2, clk_cdir, en_reg2xyz, ready};

    ln_cordic_control_fsm #(.ITER(ITER), .D(D)) dut (
        .CLK(clk), .RST(rst), .BEG_FSM(beg), .ACK_SUM(ack_sum), .CONT_ITERA(cont),
        .MS_1(ms_1), .EN_REG3(en_reg3), .EN_REG4(en_reg4), .MS_4(ms_4),
        .ADD_SUBT(add_subt), .Begin_SUM(begin_sum), .EN_REG1X(en_reg1x),
        .EN_REG1Y(en_reg1y), .EN_REG1Z(en_reg1z), .MS_2(ms_2), .MS_3(ms_3),
        .EN_REG2(en_reg2), .CLK_CDIR(clk_cdir), .EN_REG2XYZ(en_reg2xyz), .READY(ready)
    );

    // Second instance: shortest legal operation.
    logic         beg1, ack1;
    logic [D-1:0] cont1;
    logic         d1_ms_1, d1_en_reg3, d1_en_reg4, d1_add_subt, d1_begin_sum;
    logic         d1_en_reg1x, d1_en_reg1y, d1_en_reg1z, d1_en_reg2, d1_clk_cdir;
    logic         d1_en_reg2xyz, d1_ready;
    logic [1:0]   d1_ms_4, d1_ms_2, d1_ms_3;

    ln_cordic_control_fsm #(.ITER(1), .D(D)) dut1 (
        .CLK(clk), .RST(rst), .BEG_FSM(beg1), .ACK_SUM(ack1), .CONT_ITERA(cont1),
        .MS_1(d1_ms_1), .EN_REG3(d1_en_reg3), .EN_REG4(d1_en_reg4), .MS_4(d1_ms_4),
        .ADD_SUBT(d1_add_subt), .Begin_SUM(d1_begin_sum), .EN_REG1X(d1_en_reg1x),
        .EN_REG1Y(d1_en_reg1y), .EN_REG1Z(d1_en_reg1z), .MS_2(d1_ms_2), .MS_3(d1_ms_3),
        .EN_REG2(d1_en_reg2), .CLK_CDIR(d1_clk_cdir), .EN_REG2XYZ(d1_en_reg2xyz),
        .READY(d1_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int n_beg, n_cdir, n_reg4;
    int ack_cnt  = 0;
    int last_sel = 0;
    int n_beg1 = 0, n_cdir1 = 0, ack_cnt1 = 0;

    function automatic int tok(input int kind, input int val);
        return kind * 256 + val;
    endfunction

    // Operand selection seen by the adder; MS_3 only matters for shifted terms.
    function automatic int sel_code();
        return int'(ms_4) * 8 + ((ms_4 == 2'd1) ? int'(ms_3) * 2 : 0) + int'(add_subt);
    endfunction

    task automatic check_eq(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    task automatic check_tok(input string nm, input int kind, input int val);
        int got;
        int want;
        got = tok(kind, val);
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got unexpected pulse token %0d, required none", nm, got);
        end else begin
            want = exp_q.pop_front();
            if (got != want) begin
                n_fail++;
                $display("FAIL %s: got token %0d, required token %0d", nm, got, want);
            end
        end
    endtask

    // Expected pulse stream of one operation, in the order the steps occur.
    task automatic build_expect(input int iter);
        int m;
        int fl;
        int pv;
        exp_q.delete();
        exp_q.push_back(tok(K_REG3, 0));
        exp_q.push_back(tok(K_BEG, 2 * 8 + 0));
        exp_q.push_back(tok(K_R1X, 0));
        exp_q.push_back(tok(K_BEG, 2 * 8 + 1));
        exp_q.push_back(tok(K_R1Y, 0));
        exp_q.push_back(tok(K_R1Z, 1));
        for (int i = 0; i < iter; i++) begin
            exp_q.push_back(tok(K_REG2, 0));
            for (int v = 2; v >= 0; v--) begin
                pv = (v == 2) ? 1 : ((v == 1) ? 2 : 0);
                exp_q.push_back(tok(K_R2XYZ, v));
                exp_q.push_back(tok(K_BEG, 1 * 8 + pv * 2 + 0));
                if (v == 2)      exp_q.push_back(tok(K_R1X, 0));
                else if (v == 1) exp_q.push_back(tok(K_R1Y, 0));
                else             exp_q.push_back(tok(K_R1Z, 0));
            end
            exp_q.push_back(tok(K_CDIR, 0));
        end
        m  = 1 << D;
        fl = (m - (iter % m)) % m;
        for (int i = 0; i < fl; i++) exp_q.push_back(tok(K_CDIR, 0));
        exp_q.push_back(tok(K_BEG, 0 * 8 + 1));
        exp_q.push_back(tok(K_REG4, 0));
    endtask

    // Datapath iteration counters.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cont  <= '0;
            cont1 <= '0;
        end else begin
            if (clk_cdir)    cont  <= cont + 1'b1;
            if (d1_clk_cdir) cont1 <= cont1 + 1'b1;
        end
    end

    // Compare process and adder acknowledge for the main instance.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ack_cnt  = 0;
            ack_resp = 1'b0;
        end else begin
            if (en_reg3)    check_tok("en_reg3", K_REG3, 0);
            if (en_reg1x)   check_tok("en_reg1x", K_R1X, 0);
            if (en_reg1y)   check_tok("en_reg1y", K_R1Y, 0);
            if (en_reg1z)   check_tok("en_reg1z_ms1", K_R1Z, int'(ms_1));
            if (en_reg2)    check_tok("en_reg2", K_REG2, 0);
            if (en_reg2xyz) check_tok("en_reg2xyz_ms2", K_R2XYZ, int'(ms_2));
            if (begin_sum) begin
                check_tok("begin_sum_selects", K_BEG, sel_code());
                last_sel = sel_code();
                n_beg++;
            end
            if (clk_cdir) begin
                check_tok("clk_cdir", K_CDIR, 0);
                n_cdir++;
            end
            if (en_reg4) begin
                check_tok("en_reg4", K_REG4, 0);
                n_reg4++;
            end
            if (ready && exp_q.size() != 0) check_eq("ready_early", 1, 0);
            ack_resp = 1'b0;
            if (ack_cnt != 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    ack_resp = 1'b1;
                    check_eq("selects_held_at_ack", sel_code(), last_sel);
                end
            end
            if (begin_sum) ack_cnt = ACK_LAT;
        end
    end

    // Acknowledge and pulse counting for the ITER=1 instance.
    always @(negedge clk) begin
        if (rst) begin
            ack_cnt1 = 0;
            ack1     = 1'b0;
        end else begin
            if (d1_begin_sum) n_beg1++;
            if (d1_clk_cdir)  n_cdir1++;
            ack1 = 1'b0;
            if (ack_cnt1 != 0) begin
                ack_cnt1--;
                if (ack_cnt1 == 0) ack1 = 1'b1;
            end
            if (d1_begin_sum) ack_cnt1 = ACK_LAT;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_full_op(input string nm, input int storm_at);
        int cyc;
        bit storming;
        bit stormed;
        build_expect(ITER);
        n_beg    = 0;
        n_cdir   = 0;
        n_reg4   = 0;
        storming = 1'b0;
        stormed  = 1'b0;
        cyc      = 0;
        beg      = 1'b1;  // held high for the whole operation
        while (!ready && cyc < 5000) begin
            step();
            cyc++;
            // Hold ACK_SUM high from NEXT through ROM and SHIFT of one iteration.
            if (!stormed && !storming && storm_at >= 0 && clk_cdir && int'(cont) == storm_at) begin
                ack_force = 1'b1;
                storming  = 1'b1;
            end else if (storming && en_reg2xyz) begin
                ack_force = 1'b0;
                storming  = 1'b0;
                stormed   = 1'b1;
            end
        end
        ack_force = 1'b0;
        check_eq({nm, "_ready"}, int'(ready), 1);
        check_eq({nm, "_begin_sum_count"}, n_beg, 75);
        check_eq({nm, "_clk_cdir_count"}, n_cdir, 32);
        check_eq({nm, "_en_reg4_count"}, n_reg4, 1);
        check_eq({nm, "_pulses_missing"}, exp_q.size(), 0);
        check_eq({nm, "_counter_final"}, int'(cont), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq({nm, "_ready_hold"}, int'(ready), 1);
        end
        beg = 1'b0;
        step();
        check_eq({nm, "_ready_drop"}, int'(ready), 0);
        step();
        check_eq({nm, "_idle_quiet"}, int'(outs_vec), 0);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        beg       = 1'b0;
        beg1      = 1'b0;
        ack_force = 1'b0;
        ack_resp  = 1'b0;
        ack1      = 1'b0;
        step();
        step();
        check_eq("reset_outputs", int'(outs_vec), 0);

        // BEG_FSM already high when reset releases: must not start.
        beg = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("stale_beg_no_start", int'(outs_vec), 0);
        end
        beg = 1'b0;

        // ACK_SUM in IDLE changes nothing.
        ack_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("ack_in_idle", int'(outs_vec), 0);
        end
        ack_force = 1'b0;
        step();

        run_full_op("op1", 3);

        // Reset during the WAIT of the tenth iteration.
        build_expect(ITER);
        beg = 1'b1;
        cyc = 0;
        while (!(begin_sum && cont == 5'd9) && cyc < 3000) begin
            step();
            cyc++;
        end
        check_eq("reach_iter10_add", int'(begin_sum && cont == 5'd9), 1);
        step();
        check_eq("iter10_wait_ms4", int'(ms_4), 1);
        #1 rst = 1'b1;
        #1 check_eq("async_reset_outputs", int'(outs_vec), 0);
        beg = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("post_reset_idle", int'(outs_vec), 0);

        run_full_op("op_after_reset", -1);

        // ITER=1 instance.
        n_beg1  = 0;
        n_cdir1 = 0;
        beg1    = 1'b1;
        cyc     = 0;
        while (!d1_ready && cyc < 2000) begin
            step();
            cyc++;
        end
        check_eq("iter1_ready", int'(d1_ready), 1);
        check_eq("iter1_begin_sum_count", n_beg1, 6);
        check_eq("iter1_clk_cdir_count", n_cdir1, 32);
        check_eq("iter1_counter_final", int'(cont1), 0);
        beg1 = 1'b0;
        step();
        check_eq("iter1_ready_drop", int'(d1_ready), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ln_cordic_control_fsm.md
LN_CORDIC_CONTROL_FSM -- requirements
Module: ln_cordic_control_fsm

Interface
REQ-001 Parameter ITER, default 24: CORDIC iterations per operation, range 1..31.
REQ-002 Parameter D, default 5: iteration counter width.
REQ-003 Ports, one per line:
- CLK in 1: system clock.
- RST in 1: reset, asynchronous, active-high.
- BEG_FSM in 1: start request, level-sampled.
- ACK_SUM in 1: add/subtract unit done.
- CONT_ITERA in D: datapath iteration counter value.
- MS_1 out 1: Z initial-value select (1 = zero).
- EN_REG3 out 1: load the scaled T register.
- EN_REG4 out 1: load the final result register.
- MS_4 out 2: adder operand select (0 = Z,ln16; 1 = XYZ,shifted; 2 = T16,one).
- ADD_SUBT out 1: 0 = add, 1 = subtract.
- Begin_SUM out 1: adder start pulse.
- EN_REG1X, EN_REG1Y, EN_REG1Z out 1 each: current X/Y/Z register loads.
- MS_2 out 2: previous-value select (2 = X, 1 = Y, 0 = Z).
- MS_3 out 2: shifted-term select (2 = X, 1 = Y, 0 = Z).
- EN_REG2 out 1: capture shifted X/Y/Z terms.
- CLK_CDIR out 1: iteration counter increment.
- EN_REG2XYZ out 1: capture previous-value register.
- READY out 1: result valid in the result register.

Function
REQ-004 All outputs SHALL be registered Moore decodes of the state; every enable and Begin_SUM SHALL be a single-cycle pulse.
REQ-005 States SHALL be IDLE, LOAD, INIT_X, WAIT_X0, INIT_Y, WAIT_Y0, INIT_Z, ROM, SHIFT, SEL, ADD, WAIT, NEXT, FLUSH, FINAL, WAIT_F, DONE.
REQ-006 IDLE -> LOAD when BEG_FSM=1; LOAD asserts EN_REG3.
REQ-007 INIT_X: MS_4=2, ADD_SUBT=0, Begin_SUM=1. WAIT_X0 holds MS_4/ADD_SUBT until ACK_SUM=1, then pulses EN_REG1X.
REQ-008 INIT_Y/WAIT_Y0 SHALL behave as INIT_X/WAIT_X0 with ADD_SUBT=1 and EN_REG1Y.
REQ-009 INIT_Z SHALL assert MS_1=1 and EN_REG1Z.
REQ-010 ROM SHALL be one idle cycle for the synchronous shift and arctan ROMs to settle; SHIFT SHALL pulse EN_REG2.
REQ-011 An internal 2-bit variable index v SHALL sequence X(2), Y(1), Z(0).
- SEL: MS_2=v, EN_REG2XYZ=1.
- ADD: MS_4=1, MS_3 = partner of v (X->Y=1, Y->X=2, Z->Z=0), ADD_SUBT=0, Begin_SUM=1.
- WAIT: same selects held; on ACK_SUM=1, pulse EN_REG1 for v with MS_1=0, then go to SEL with the next v, or to NEXT after Z.
REQ-012 NEXT SHALL pulse CLK_CDIR. If CONT_ITERA = ITER-1 (pre-increment value), go to FLUSH; otherwise go to ROM.
REQ-013 FLUSH SHALL pulse CLK_CDIR every other cycle until CONT_ITERA = 0, leaving the counter at 0 for the next operation, then go to FINAL.
REQ-014 FINAL: MS_4=0, ADD_SUBT=1, Begin_SUM=1. WAIT_F waits for ACK_SUM, then pulses EN_REG4 and enters DONE.
REQ-015 DONE SHALL hold READY=1 until BEG_FSM=0, then go to IDLE. READY SHALL be 0 in every other state.
REQ-016 BEG_FSM SHALL be ignored outside IDLE and DONE.
REQ-017 ACK_SUM SHALL be ignored outside WAIT* states, and in the same cycle as Begin_SUM.
REQ-018 ACK_SUM SHALL have no timeout; the FSM waits indefinitely.
REQ-019 A full operation SHALL issue exactly 3*ITER+3 Begin_SUM pulses.

Reset
REQ-020 RST=1 SHALL force IDLE, all outputs 0 and v=2 asynchronously, including mid-operation.
REQ-021 After reset, the next operation SHALL start only on a fresh BEG_FSM=1.

Structure
REQ-022 State encoding, MS_2/MS_3/MS_4 select constants and the ln16/one constant names SHALL live in a shared package.
REQ-023 No sub-module is required. The per-variable SEL/ADD/WAIT triplet SHALL be a single state group indexed by v, not three copies.

Verification
REQ-024 Directed scenarios:
- ITER=24, ACK_SUM returned 3 cycles after each Begin_SUM -> 75 Begin_SUM pulses, 24 iteration CLK_CDIR pulses plus flush pulses to CONT_ITERA=0, one EN_REG4 pulse, then READY=1.
- Per iteration -> EN_REG1X, EN_REG1Y, EN_REG1Z in that order; MS_3 = 1, 2, 0 during the respective ADDs.
- RST asserted during WAIT of iteration 10 -> all outputs 0 in the same cycle; a new BEG_FSM runs normally.
- ACK_SUM=1 held in IDLE and SHIFT -> no state change and no EN_REG1* pulse.
- BEG_FSM held high through DONE -> READY stays 1; BEG_FSM low -> IDLE next cycle.
- ITER=1 -> 6 Begin_SUM pulses, then READY.
